shift_result_stage: RTL and testbench
=====================================

Name: shift_result_stage

Overview:
- Pipeline stage directly downstream of the barrel shifter in the EX7 ALU datapath.
- Registers the shifter's 32-bit result and carry-out behind a valid/ready handshake with a 2-entry skid buffer.
- Maintains the architectural status flags Z, N and C.
- Feeds the write-back stage, and fixes the undefined carry the shifter produces for a zero shift amount.

Parameters:
- WIDTH, 32, data width of the result path. The flag logic assumes the MSB is the sign bit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready
- in_result  in  WIDTH  shifter output c
- in_carry  in  1  shifter carry-out
- in_op  in  2  shift op: 00 arithmetic right, 01 logical right, 10/11 left
- in_amt  in  5  shift amount used for this result
- in_flags_we  in  1  this instruction updates flags
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready
- out_result  out  WIDTH  registered result
- out_op  out  2  registered op, for write-back muxing
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag
- flag_c  out  1  carry flag

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, in_ready=1, out_result=0, out_op=0, flag_z=0, flag_n=0, flag_c=0, skid entry invalidated.
- Reset mid-transfer drops both held entries silently; no partial output.
- Storage: a main register (drives the outputs) and one skid register. State machine:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: main full, skid full.
- in_ready is a registered signal, equal to (state != TWO). It never depends combinationally on out_ready.
- Transitions:
  - EMPTY + accept -> ONE. Data goes to main; out_valid rises the next cycle, so latency is 1 cycle.
  - ONE + accept + out_ready -> ONE. Main reloads with the new data.
  - ONE + accept + !out_ready -> TWO. Data goes to skid.
  - ONE + !accept + out_ready -> EMPTY.
  - TWO + out_ready -> ONE. Skid moves to main. in_ready=0 in TWO, so no accept is possible.
  - All other combinations hold state.
- Ordering is strictly FIFO. No entry is dropped or duplicated. out_result is stable while out_valid=1 and out_ready=0.
- Flags update at the accept edge, independent of downstream stalls, and only when in_flags_we=1:
  - flag_z = (in_result == 0)
  - flag_n = in_result[WIDTH-1]
  - flag_c = in_carry if in_amt != 0; otherwise flag_c holds its previous value. This is required because the shifter's carry is undefined for a zero shift.
- When in_flags_we=0, all flags hold.
- When in_flags_we=1 and in_amt=0, Z and N still update.
- in_op does not affect the flag rules. It is carried through to out_op unchanged.
- Simultaneous accept and emit in state ONE is legal and gives full throughput: one result per cycle.

Optional Feature:
- Macro: SHIFT_RESULT_STATS_EN.
- When defined, two extra outputs are added:
  - stat_accepts (32-bit): increments on every input transfer.
  - stat_stalls (32-bit): increments every cycle where out_valid & !out_ready.
- Both counters reset to 0 on rst and wrap modulo 2^32.
- When not defined, these ports and their logic do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package or include file (alu_defs), holding:
  - SHIFT_SRA=2'b00, SHIFT_SRL=2'b01, SHIFT_SLL=2'b10.
  - State encodings EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - WIDTH default.
- One sub-module is natural: shift_flag_unit, the combinational Z/N/C next-value logic including the amt==0 carry hold. It is instantiated once. The handshake and storage stay in the top module.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, all flags 0, out_result=0.
2. Single transfer: in_result=32'h8000_0000, in_carry=1, in_amt=3, in_flags_we=1, out_ready=1 -> one cycle later out_valid=1, out_result=32'h8000_0000, flag_n=1, flag_z=0, flag_c=1.
3. Zero-amount carry hold: first flag_c=1; then accept in_result=0, in_carry=0, in_amt=0, in_flags_we=1 -> flag_z=1, flag_n=0, flag_c stays 1.
4. Backpressure: out_ready=0, send 32'h1 then 32'h2 -> state TWO, in_ready=0 the next cycle. Then raise out_ready -> outputs 32'h1 then 32'h2, in order, with no loss.
5. Full throughput: out_ready=1, in_valid=1 for 8 cycles with results 1..8 -> out_result sequence 1..8 on consecutive cycles, in_ready constant 1.
6. Reset mid-stall: reach state TWO, assert rst -> next cycle out_valid=0, in_ready=1. With SHIFT_RESULT_STATS_EN defined, stat_accepts=0 and stat_stalls=0.

Source files
------------

// File: rtl/alu_defs.sv
// Shared EX7 ALU definitions: shift op codes, result-stage state encodings and default width.
package alu_defs;

   localparam int unsigned WIDTH_DEF = 32;

   localparam logic [1:0] SHIFT_SRA = 2'b00;
   localparam logic [1:0] SHIFT_SRL = 2'b01;
   localparam logic [1:0] SHIFT_SLL = 2'b10;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

endpackage

// File: rtl/shift_flag_unit.sv
// Next-value logic for the Z/N/C status flags fed by the shifter result.
module shift_flag_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             update,
   input  logic [WIDTH-1:0] result,
   input  logic             carry,
   input  logic [4:0]       amt,
   input  logic             z_cur,
   input  logic             n_cur,
   input  logic             c_cur,
   output logic             z_nxt,
   output logic             n_nxt,
   output logic             c_nxt
);

   always_comb begin
      z_nxt = z_cur;
      n_nxt = n_cur;
      c_nxt = c_cur;
      if (update) begin
         z_nxt = (result == '0);
         n_nxt = result[WIDTH-1];
         // Shifter carry is undefined for a zero shift, so C keeps its old value.
         if (amt != 5'd0) begin
            c_nxt = carry;
         end
      end
   end

endmodule

// File: rtl/shift_result_stage.sv
// Shifter result stage: 2-entry skid buffer, Z/N/C flags, write-back feed.
// Optional counters stat_accepts/stat_stalls exist when SHIFT_RESULT_STATS_EN is defined.
module shift_result_stage
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   input  logic [1:0]       in_op,
   input  logic [4:0]       in_amt,
   input  logic             in_flags_we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [1:0]       out_op,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
`ifdef SHIFT_RESULT_STATS_EN
   ,
   output logic [31:0]      stat_accepts,
   output logic [31:0]      stat_stalls
`endif
);

   stage_state_e     state_q, state_d;
   logic [WIDTH-1:0] main_res_q, main_res_d, skid_res_q, skid_res_d;
   logic [1:0]       main_op_q, main_op_d, skid_op_q, skid_op_d;
   logic             in_ready_q;
   logic             z_q, n_q, c_q, z_d, n_d, c_d;
   logic             accept;

   assign accept     = in_valid & in_ready_q;
   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_result = main_res_q;
   assign out_op     = main_op_q;
   assign flag_z     = z_q;
   assign flag_n     = n_q;
   assign flag_c     = c_q;

   always_comb begin
      state_d    = state_q;
      main_res_d = main_res_q;
      main_op_d  = main_op_q;
      skid_res_d = skid_res_q;
      skid_op_d  = skid_op_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d    = ONE;
               main_res_d = in_result;
               main_op_d  = in_op;
            end
         end
         ONE: begin
            if (accept) begin
               if (out_ready) begin
                  main_res_d = in_result;
                  main_op_d  = in_op;
               end else begin
                  state_d    = TWO;
                  skid_res_d = in_result;
                  skid_op_d  = in_op;
               end
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_ready) begin
               state_d    = ONE;
               main_res_d = skid_res_q;
               main_op_d  = skid_op_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   shift_flag_unit #(
      .WIDTH (WIDTH)
   ) u_flags (
      .update (accept & in_flags_we),
      .result (in_result),
      .carry  (in_carry),
      .amt    (in_amt),
      .z_cur  (z_q),
      .n_cur  (n_q),
      .c_cur  (c_q),
      .z_nxt  (z_d),
      .n_nxt  (n_d),
      .c_nxt  (c_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_res_q <= '0;
         main_op_q  <= 2'b00;
         skid_res_q <= '0;
         skid_op_q  <= 2'b00;
         in_ready_q <= 1'b1;
         z_q        <= 1'b0;
         n_q        <= 1'b0;
         c_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_res_q <= main_res_d;
         main_op_q  <= main_op_d;
         skid_res_q <= skid_res_d;
         skid_op_q  <= skid_op_d;
         // Registered so upstream never sees a combinational path from out_ready.
         in_ready_q <= (state_d != TWO);
         z_q        <= z_d;
         n_q        <= n_d;
         c_q        <= c_d;
      end
   end

`ifdef SHIFT_RESULT_STATS_EN
   logic [31:0] accepts_q, stalls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         accepts_q <= '0;
         stalls_q  <= '0;
      end else begin
         if (accept) begin
            accepts_q <= accepts_q + 32'd1;
         end
         if (out_valid && !out_ready) begin
            stalls_q <= stalls_q + 32'd1;
         end
      end
   end

   assign stat_accepts = accepts_q;
   assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Scoreboard bench for shift_result_stage; also covers SHIFT_RESULT_STATS_EN when defined.
module tb_shift_result_stage;
   import alu_defs::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_result = '0;
   logic         in_carry = 1'b0;
   logic [1:0]   in_op = 2'b00;
   logic [4:0]   in_amt = 5'd0;
   logic         in_flags_we = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic [1:0]   out_op;
   logic         flag_z, flag_n, flag_c;
`ifdef SHIFT_RESULT_STATS_EN
   logic [31:0]  stat_accepts, stat_stalls;
`endif

   shift_result_stage #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_carry    (in_carry),
      .in_op       (in_op),
      .in_amt      (in_amt),
      .in_flags_we (in_flags_we),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_op      (out_op),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_c      (flag_c)
`ifdef SHIFT_RESULT_STATS_EN
      ,
      .stat_accepts (stat_accepts),
      .stat_stalls  (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] res;
      logic [1:0]   op;
   } entry_t;

   entry_t       sb[$];
   logic         mz = 1'b0, mn = 1'b0, mc = 1'b0;
   bit           model_on = 1'b0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_res = '0;
   int           emits = 0;
   logic [31:0]  m_acc = '0, m_stl = '0;

   // Inputs only change at posedge+1, so the negedge sees what the next posedge will act on.
   always @(negedge clk) begin
      entry_t e;
      if (model_on) begin
         check_val("flag_z", flag_z, mz);
         check_val("flag_n", flag_n, mn);
         check_val("flag_c", flag_c, mc);
`ifdef SHIFT_RESULT_STATS_EN
         check_val("stat_accepts", stat_accepts, m_acc);
         check_val("stat_stalls", stat_stalls, m_stl);
`endif
      end
      if (prev_stall) begin
         check_val("stall_valid", out_valid, 1'b1);
         check_val("stall_stable", out_result, prev_res);
      end
      if (rst) begin
         sb.delete();
         mz = 1'b0; mn = 1'b0; mc = 1'b0;
         m_acc = '0; m_stl = '0;
         model_on = 1'b1;
         prev_stall = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_val("spurious_out", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check_val("out_result", out_result, e.res);
               check_val("out_op", out_op, e.op);
            end
            emits++;
         end
         if (in_valid && in_ready) begin
            sb.push_back('{res: in_result, op: in_op});
            if (in_flags_we) begin
               mz = (in_result == '0);
               mn = in_result[W-1];
               if (in_amt != 5'd0) mc = in_carry;
            end
            m_acc = m_acc + 32'd1;
         end
         if (out_valid && !out_ready) m_stl = m_stl + 32'd1;
         prev_stall = out_valid && !out_ready;
         prev_res   = out_result;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] r, input logic c, input logic [1:0] op,
                        input logic [4:0] amt, input logic we);
      in_valid = v; in_result = r; in_carry = c; in_op = op; in_amt = amt; in_flags_we = we;
      step();
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) step();
      check_val("drain", sb.size(), 0);
   endtask

   initial begin
      int base;
      // 1. reset then idle
      repeat (2) step();
      rst = 1'b0;
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_out_result", out_result, '0);
      check_val("rst_out_op", out_op, 2'b00);
      step();

      // 2. single transfer, 1-cycle latency
      out_ready = 1'b1;
      drive(1'b1, 32'h8000_0000, 1'b1, SHIFT_SLL, 5'd3, 1'b1);
      in_valid = 1'b0;
      check_val("t2_out_valid", out_valid, 1'b1);
      check_val("t2_out_result", out_result, 32'h8000_0000);
      check_val("t2_flag_n", flag_n, 1'b1);
      check_val("t2_flag_c", flag_c, 1'b1);
      step();

      // 3. zero amount holds carry, Z/N still update
      drive(1'b1, 32'h0, 1'b0, SHIFT_SRL, 5'd0, 1'b1);
      in_valid = 1'b0;
      check_val("t3_flag_z", flag_z, 1'b1);
      check_val("t3_flag_n", flag_n, 1'b0);
      check_val("t3_flag_c", flag_c, 1'b1);
      // flags hold with we=0
      drive(1'b1, 32'hF000_0005, 1'b0, SHIFT_SRA, 5'd4, 1'b0);
      in_valid = 1'b0;
      check_val("t3_hold_z", flag_z, 1'b1);
      step();

      // 4. backpressure into TWO, then ordered drain
      out_ready = 1'b0;
      drive(1'b1, 32'h1, 1'b0, SHIFT_SRA, 5'd1, 1'b1);
      drive(1'b1, 32'h2, 1'b1, SHIFT_SRL, 5'd2, 1'b1);
      check_val("t4_in_ready", in_ready, 1'b0);
      check_val("t4_head", out_result, 32'h1);
      drive(1'b1, 32'h3, 1'b0, SHIFT_SLL, 5'd1, 1'b1);
      in_valid = 1'b0;
      base = emits;
      out_ready = 1'b1;
      wait_drain();
      check_val("t4_emits", emits - base, 2);

      // 5. full throughput
      step();
      base = emits;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, W'(i), i[0], 2'(i), 5'(i), 1'b1);
         check_val("t5_in_ready", in_ready, 1'b1);
      end
      in_valid = 1'b0;
      step();
      check_val("t5_emits", emits - base, 8);
      wait_drain();

      // 6. reset mid-stall
      out_ready = 1'b0;
      drive(1'b1, 32'h7, 1'b1, SHIFT_SRA, 5'd5, 1'b1);
      drive(1'b1, 32'h8, 1'b0, SHIFT_SRL, 5'd6, 1'b1);
      in_valid = 1'b0;
      check_val("t6_in_ready_two", in_ready, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("t6_out_valid", out_valid, 1'b0);
      check_val("t6_in_ready", in_ready, 1'b1);
      check_val("t6_flag_c", flag_c, 1'b0);
`ifdef SHIFT_RESULT_STATS_EN
      check_val("t6_stat_accepts", stat_accepts, 32'd0);
      check_val("t6_stat_stalls", stat_stalls, 32'd0);
`endif
      out_ready = 1'b1;
      repeat (3) step();
      check_val("t6_no_out", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
